ifmap_row_feeder: RTL and testbench
===================================

// Module: ifmap_row_feeder
// PURPOSE
//  Upstream feeder for the PE datapath IFMap FIFO. Streams row_count rows of row_len words from a
//  linear on-chip memory (1-cycle read latency) into the PE IFMap buffer. Tags each word with
//  start/end-of-row flags. Flow control uses a credit counter that mirrors the PE FIFO occupancy.
// PARAMETERS
//  DATA_WIDTH    16   payload width of one IFMap element
//  IFMAP_WIDTH   18   word width pushed to PE; must equal DATA_WIDTH+2 (two tag bits)
//  ADDR_WIDTH    10   memory address width
//  LEN_SIZE      8    width of row_len and row_count
//  FIFO_DEPTH    16   depth of the PE IFMap FIFO = initial/max credits
// PORTS
//  clk               in   1            clock
//  rst               in   1            synchronous active-high reset
//  start             in   1            pulse: latch base_addr/row_len/row_count, begin transfer
//  base_addr         in   ADDR_WIDTH   address of first element of row 0
//  row_len           in   LEN_SIZE     words per row
//  row_count         in   LEN_SIZE     rows to send
//  mem_ren           out  1            memory read enable
//  mem_addr          out  ADDR_WIDTH   memory read address
//  mem_rdata         in   DATA_WIDTH   memory data, valid the cycle after mem_ren
//  credit_return     in   1            PE popped one IFMap FIFO entry this cycle
//  IFMap_out         out  IFMAP_WIDTH  {sor, eor, payload} to PE IFMap_in
//  wen_IFMap_buffer  out  1            write strobe to PE IFMap FIFO
//  busy              out  1            high in RUN and DRAIN
//  done              out  1            one-cycle pulse at end of transfer
//  credit_err        out  1            sticky: credit_return seen with credits==FIFO_DEPTH
// BEHAVIOUR
//  Reset: state=IDLE; mem_ren=0, mem_addr=0, wen_IFMap_buffer=0, IFMap_out=0, busy=0, done=0,
//   credit_err=0, credits=FIFO_DEPTH. Reset mid-transfer aborts immediately; no further writes.
//  FSM IDLE->RUN->DRAIN->DONE->IDLE:
//   IDLE:  on start, latch params, ptr=base_addr, col=0, row=0.
//          If row_len==0 or row_count==0, go to DONE. Otherwise go to RUN.
//          start is ignored in every state except IDLE.
//   RUN:   issue = (credits!=0). On issue: mem_ren=1, mem_addr=ptr, credits--, ptr++ (mod 2^ADDR_WIDTH),
//          col++. col wraps to 0 at row_len-1 and increments row.
//          Issuing the last word (row==row_count-1, col==row_len-1) -> DRAIN.
//   DRAIN: 1 cycle; the final write completes here -> DONE.
//   DONE:  done=1 for exactly one cycle -> IDLE.
//  Tags are pipelined with the read: sor=(col==0), eor=(col==row_len-1), both captured at issue.
//   row_len==1 sets sor and eor on the same word.
//  Latency: mem_ren at cycle t -> wen_IFMap_buffer=1 at t+1 with
//   IFMap_out={sor,eor,mem_rdata[DATA_WIDTH-1:0]}. Exactly one write per issue; order preserved.
//  Credits: width $clog2(FIFO_DEPTH+1).
//   Issue and credit_return in the same cycle -> count unchanged.
//   credit_return alone -> ++, saturating at FIFO_DEPTH; a return at the cap sets credit_err.
//   credits==0 stalls issue only; the in-flight write still completes.
//   Credits persist across transfers; they are not reloaded on start.
//  Throughput: 1 word/cycle while credits>0. Never more than FIFO_DEPTH unreturned writes.
//  IFMap_out holds its last value when wen_IFMap_buffer=0.
// TESTING
//  1. base=0x010, row_len=3, row_count=2, mem[i]=i, no returns -> 6 writes on consecutive cycles,
//     payloads 0x10..0x15; tags {10},{00},{01},{10},{00},{01}; done 2 cycles after last mem_ren.
//  2. FIFO_DEPTH=4, row_len=8, row_count=1, no returns -> exactly 4 writes, then stall with busy=1.
//     Pulse credit_return 4 times -> remaining 4 writes; then done.
//  3. row_len=1, row_count=3 -> 3 writes, each tagged sor=eor=1.
//     row_count=0 -> no mem_ren, done 2 cycles after start.
//  4. base=0x3FE, row_len=4, ADDR_WIDTH=10 -> mem_addr sequence 0x3FE, 0x3FF, 0x000, 0x001.
//  5. Assert rst at the 3rd issue of a 16-word transfer -> next cycle all outputs 0, busy=0,
//     credits=FIFO_DEPTH. start during busy has no effect.
//  6. credit_return with credits==FIFO_DEPTH -> credit_err=1 and stays set; credits unchanged.
//     Simultaneous issue+return keeps credits constant.

Source files
------------

// File: rtl/ifmap_row_feeder_if.sv
// Feeder bus bundle: memory read port plus PE IFMap write port and credit return.
// The master side is the feeder; the slave side is memory plus the PE buffer.
interface ifmap_row_feeder_if #(
  parameter int DATA_WIDTH  = 16,
  parameter int IFMAP_WIDTH = 18,
  parameter int ADDR_WIDTH  = 10
);
  logic                   mem_ren;
  logic [ADDR_WIDTH-1:0]  mem_addr;
  logic [DATA_WIDTH-1:0]  mem_rdata;
  logic                   credit_return;
  logic [IFMAP_WIDTH-1:0] IFMap_out;
  logic                   wen_IFMap_buffer;

  modport master (
    output mem_ren, mem_addr, IFMap_out, wen_IFMap_buffer,
    input  mem_rdata, credit_return
  );

  modport slave (
    input  mem_ren, mem_addr, IFMap_out, wen_IFMap_buffer,
    output mem_rdata, credit_return
  );
endinterface

// File: rtl/ifmap_row_feeder.sv
// Streams row_count x row_len words from 1-cycle-latency memory into the PE IFMap FIFO, tagged {sor,eor}.
// Write lands one cycle after mem_ren; issue stalls while credits==0, in-flight writes still complete.
module ifmap_row_feeder #(
  parameter int DATA_WIDTH  = 16,
  parameter int IFMAP_WIDTH = 18,
  parameter int ADDR_WIDTH  = 10,
  parameter int LEN_SIZE    = 8,
  parameter int FIFO_DEPTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [LEN_SIZE-1:0]   row_len,
  input  logic [LEN_SIZE-1:0]   row_count,
  ifmap_row_feeder_if.master    bus,
  output logic                  busy,
  output logic                  done,
  output logic                  credit_err
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t                 state;
  logic [ADDR_WIDTH-1:0]  ptr;
  logic [LEN_SIZE-1:0]    col, row, len_q, cnt_q;
  logic [CW-1:0]          credits;
  logic                   mem_ren_q, wen_q;
  logic [ADDR_WIDTH-1:0]  mem_addr_q;
  logic [1:0]             tag_rd, tag_wr;
  logic [IFMAP_WIDTH-1:0] out_hold;
  logic                   issue, last_col, last_row;

  assign issue    = (state == RUN) && (credits != '0);
  assign last_col = (col == len_q - LEN_SIZE'(1));
  assign last_row = (row == cnt_q - LEN_SIZE'(1));

  // Read data arrives unregistered, so the output muxes it in on the write cycle and holds otherwise.
  assign bus.mem_ren          = mem_ren_q;
  assign bus.mem_addr         = mem_addr_q;
  assign bus.wen_IFMap_buffer = wen_q;
  assign bus.IFMap_out        = wen_q ? IFMAP_WIDTH'({tag_wr, bus.mem_rdata}) : out_hold;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      col        <= '0;
      row        <= '0;
      len_q      <= '0;
      cnt_q      <= '0;
      credits    <= CREDIT_MAX;
      credit_err <= 1'b0;
      mem_ren_q  <= 1'b0;
      mem_addr_q <= '0;
      wen_q      <= 1'b0;
      tag_rd     <= '0;
      tag_wr     <= '0;
      out_hold   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      mem_ren_q <= issue;
      wen_q     <= mem_ren_q;
      tag_wr    <= tag_rd;
      done      <= (state == DONE);
      if (wen_q)
        out_hold <= IFMAP_WIDTH'({tag_wr, bus.mem_rdata});

      // Simultaneous issue and return cancel out; a return at the cap is a protocol error.
      if (issue && !bus.credit_return)
        credits <= credits - CW'(1);
      else if (!issue && bus.credit_return) begin
        if (credits == CREDIT_MAX)
          credit_err <= 1'b1;
        else
          credits <= credits + CW'(1);
      end

      case (state)
        IDLE: begin
          if (start) begin
            len_q <= row_len;
            cnt_q <= row_count;
            ptr   <= base_addr;
            col   <= '0;
            row   <= '0;
            if (row_len == '0 || row_count == '0) begin
              state <= DONE;
              busy  <= 1'b0;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue) begin
            mem_addr_q <= ptr;
            tag_rd     <= {col == '0, last_col};
            ptr        <= ptr + ADDR_WIDTH'(1);
            if (last_col) begin
              col <= '0;
              row <= row + LEN_SIZE'(1);
            end else begin
              col <= col + LEN_SIZE'(1);
            end
            if (last_col && last_row)
              state <= DRAIN;
          end
        end
        DRAIN: begin
          state <= DONE;
          busy  <= 1'b0;
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ifmap_row_feeder.sv
// Randomized bench for ifmap_row_feeder against a queue-based transfer model, plus pinned directed cases.
module tb_ifmap_row_feeder;
  localparam int DW = 16, IW = 18, AW = 10, LW = 8, DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] base_addr = '0;
  logic [LW-1:0] row_len = '0, row_count = '0;
  logic          busy, done, credit_err;

  ifmap_row_feeder_if #(.DATA_WIDTH(DW), .IFMAP_WIDTH(IW), .ADDR_WIDTH(AW)) bus ();

  ifmap_row_feeder #(.DATA_WIDTH(DW), .IFMAP_WIDTH(IW), .ADDR_WIDTH(AW),
                     .LEN_SIZE(LW), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .row_len(row_len), .row_count(row_count), .bus(bus),
    .busy(busy), .done(done), .credit_err(credit_err)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) if (bus.mem_ren) bus.mem_rdata <= mem[bus.mem_addr];

  int checks = 0, errors = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
    end
  endtask

  // Model state: a transfer is a list of addresses and tagged words; credits bound outstanding issues.
  logic [AW-1:0] addr_q[$];
  logic [IW-1:0] word_q[$];
  logic [IW-1:0] wlog[$];
  logic [AW-1:0] alog[$];
  logic [IW-1:0] last_out = '0;
  logic [AW-1:0] p_base = '0;
  logic [LW-1:0] p_len = '0, p_cnt = '0;
  bit p_rst = 1'b1, p_start = 1'b0, p_ret = 1'b0, p_run = 1'b0, p_ren = 1'b0;
  bit active = 1'b0, run = 1'b0, err_m = 1'b0, ren_e, wen_e;
  int p_cred = DEPTH, cred = DEPTH, cyc_n = 0, done_at = -1;
  int occ = 0, done_cnt = 0, issue_cnt = 0, mode = 0;

  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      cyc_n++;
      ren_e = 1'b0;
      if (p_rst) begin
        addr_q.delete(); word_q.delete();
        active = 0; run = 0; err_m = 0; cred = DEPTH; last_out = '0; done_at = -1; occ = 0;
        chk("rst_mem_ren", 32'(bus.mem_ren), 0);
        chk("rst_mem_addr", 32'(bus.mem_addr), 0);
        chk("rst_wen", 32'(bus.wen_IFMap_buffer), 0);
        chk("rst_IFMap_out", 32'(bus.IFMap_out), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_credit_err", 32'(credit_err), 0);
      end else begin
        ren_e = p_run && (p_cred > 0);
        chk("mem_ren", 32'(bus.mem_ren), 32'(ren_e));
        if (ren_e && bus.mem_ren) begin
          chk("mem_addr", 32'(bus.mem_addr), 32'(addr_q.pop_front()));
          alog.push_back(bus.mem_addr);
          issue_cnt++;
          if (addr_q.size() == 0) begin
            run = 0;
            done_at = cyc_n + 2;
          end
        end
        wen_e = p_ren;
        chk("wen", 32'(bus.wen_IFMap_buffer), 32'(wen_e));
        if (wen_e) begin
          last_out = word_q.pop_front();
          wlog.push_back(bus.IFMap_out);
          occ++;
        end
        chk("IFMap_out", 32'(bus.IFMap_out), 32'(last_out));
        if (ren_e && !p_ret) cred--;
        else if (!ren_e && p_ret) begin
          if (cred == DEPTH) err_m = 1;
          else cred++;
        end
        if (p_start && !active) begin
          active = 1;
          if (p_len == 0 || p_cnt == 0) done_at = cyc_n + 1;
          else begin
            run = 1;
            for (int r = 0; r < int'(p_cnt); r++)
              for (int c = 0; c < int'(p_len); c++) begin
                logic [AW-1:0] a;
                a = AW'(int'(p_base) + r * int'(p_len) + c);
                addr_q.push_back(a);
                word_q.push_back({c == 0, c == int'(p_len) - 1, mem[a]});
              end
          end
        end
        chk("busy", 32'(busy), 32'(run || ren_e));
        chk("done", 32'(done), 32'(done_at == cyc_n));
        if (done_at == cyc_n) active = 0;
        if (done) done_cnt++;
        chk("credit_err", 32'(credit_err), 32'(err_m));
        chk("pe_fifo_bound", 32'(occ <= DEPTH), 1);
        if (bus.credit_return) occ--;
      end
      p_rst = rst; p_start = start; p_ret = bus.credit_return;
      p_run = run; p_cred = cred; p_ren = ren_e;
      p_base = base_addr; p_len = row_len; p_cnt = row_count;
    end
  end

  // Inputs change 1 time unit after the rising edge; mode 0 = no returns, 1 = random, 2 = eager.
  task automatic cyc();
    @(posedge clk);
    #1;
    start = 1'b0;
    if (mode == 2) bus.credit_return = (occ > 0);
    else if (mode == 1) bus.credit_return = (occ > 0) && ($urandom_range(0, 2) != 0);
    else bus.credit_return = 1'b0;
  endtask

  task automatic settle(input int k);
    repeat (k) cyc();
  endtask

  task automatic drain();
    mode = 2;
    settle(12);
  endtask

  task automatic wait_done(input int budget, input int d0);
    for (int i = 0; i < budget; i++) begin
      if (done_cnt != d0) return;
      cyc();
    end
    checks++;
    errors++;
    $display("FAIL wait_done: no done within %0d cycles", budget);
  endtask

  task automatic kick(input logic [AW-1:0] b, input int len, input int cnt);
    cyc();
    base_addr = b; row_len = LW'(len); row_count = LW'(cnt); start = 1'b1;
  endtask

  task automatic xfer(input logic [AW-1:0] b, input int len, input int cnt);
    int d0;
    d0 = done_cnt;
    kick(b, len, cnt);
    wait_done(800, d0);
  endtask

  initial begin
    int i0, d0;
    bit did;
    bus.credit_return = 1'b0;
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'(i);
    settle(2);
    rst = 1'b0;

    // Row/tag pattern with consecutive writes
    mode = 2; wlog.delete();
    xfer(10'h010, 3, 2);
    settle(4);
    chk("t1_count", wlog.size(), 6);
    chk("t1_w0", 32'(wlog[0]), 32'h20010);
    chk("t1_w1", 32'(wlog[1]), 32'h00011);
    chk("t1_w2", 32'(wlog[2]), 32'h10012);
    chk("t1_w3", 32'(wlog[3]), 32'h20013);
    chk("t1_w5", 32'(wlog[5]), 32'h10015);
    drain();

    // Credit exhaustion stalls after DEPTH writes
    mode = 0; wlog.delete();
    d0 = done_cnt;
    kick(10'h040, 8, 1);
    settle(15);
    chk("t2_stall_writes", wlog.size(), DEPTH);
    chk("t2_stall_busy", 32'(busy), 1);
    mode = 2;
    wait_done(100, d0);
    settle(3);
    chk("t2_total_writes", wlog.size(), 8);
    drain();

    // Single-word rows and zero-length transfer
    mode = 1; wlog.delete();
    xfer(10'h100, 1, 3);
    settle(6);
    chk("t3_count", wlog.size(), 3);
    for (int i = 0; i < 3; i++) chk("t3_sor_eor", 32'(wlog[i][IW-1:IW-2]), 3);
    drain();
    alog.delete();
    xfer(10'h200, 5, 0);
    chk("t3_zero_no_ren", alog.size(), 0);

    // Address wrap
    alog.delete();
    xfer(10'h3FE, 4, 1);
    drain();
    chk("t4_a0", 32'(alog[0]), 32'h3FE);
    chk("t4_a1", 32'(alog[1]), 32'h3FF);
    chk("t4_a2", 32'(alog[2]), 32'h000);
    chk("t4_a3", 32'(alog[3]), 32'h001);

    // Reset mid-transfer, with an ignored start while busy
    mode = 1; i0 = issue_cnt; did = 0;
    kick(10'h080, 8, 2);
    for (int i = 0; i < 200 && rst == 1'b0; i++) begin
      cyc();
      if (busy && !did) begin
        base_addr = 10'h300; row_len = 2; row_count = 1; start = 1'b1; did = 1;
      end else if (issue_cnt - i0 >= 3) begin
        mode = 0;
        rst = 1'b1;
      end
    end
    chk("t5_rst_reached", 32'(rst), 1);
    cyc();
    rst = 1'b0;
    chk("t5_busy_after_rst", 32'(busy), 0);
    chk("t5_wen_after_rst", 32'(bus.wen_IFMap_buffer), 0);
    chk("t5_out_after_rst", 32'(bus.IFMap_out), 0);
    settle(4);
    chk("t5_no_late_issue", 32'(bus.mem_ren), 0);

    // Return at the cap flags a sticky error; eager returns overlap issues
    mode = 0;
    settle(3);
    cyc();
    bus.credit_return = 1'b1;
    settle(3);
    chk("t6_err_set", 32'(credit_err), 1);
    settle(5);
    chk("t6_err_sticky", 32'(credit_err), 1);
    mode = 2;
    xfer(10'h050, 6, 2);
    drain();

    // Randomized transfers
    for (int i = 0; i < (1 << AW); i++) mem[i] = DW'($urandom);
    for (int t = 0; t < 30; t++) begin
      mode = ($urandom_range(0, 3) == 0) ? 2 : 1;
      xfer(AW'($urandom), $urandom_range(0, 10), $urandom_range(0, 4));
      settle($urandom_range(0, 3));
    end
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
